// File: rtl/pipe_hazard_tracker_if.sv
// Issue-side bundle and hazard responses for pipe_hazard_tracker.
// master = ID stage driving issue fields; slave = the tracker.
interface pipe_hazard_tracker_if #(
    parameter int RIDX_W = 5,
    parameter int SEL_W  = 2
);
    logic              issue_valid;
    logic [RIDX_W-1:0] issue_rs;
    logic [RIDX_W-1:0] issue_rt;
    logic              use_rs;
    logic              use_rt;
    logic [RIDX_W-1:0] issue_rw;
    logic              issue_regwr;
    logic              issue_load;
    logic              flush;
    logic              stall_o;
    logic [SEL_W-1:0]  fwd_sel_a;
    logic [SEL_W-1:0]  fwd_sel_b;
    logic [15:0]       stall_cnt;

    modport master (
        output issue_valid, issue_rs, issue_rt,
        output use_rs, use_rt, issue_rw,
        output issue_regwr, issue_load, flush,
        input  stall_o, fwd_sel_a, fwd_sel_b,
        input  stall_cnt
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt,
        input  use_rs, use_rt, issue_rw,
        input  issue_regwr, issue_load, flush,
        output stall_o, fwd_sel_a, fwd_sel_b,
        output stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_tracker.sv
// Pipeline hazard tracker: forwarding selects and load-use stall.
// HZT_STALL_CNT_EN enables the saturating stall-cycle counter.
module pipe_hazard_tracker #(
    parameter int DEPTH      = 3,
    parameter int RIDX_W     = 5,
    parameter int LOAD_AVAIL = 2,
    parameter int SEL_W      = 2
) (
    input  logic CLK,
    input  logic Reset_L,
    pipe_hazard_tracker_if.slave hz
);

    typedef struct packed {
        logic              valid;
        logic [RIDX_W-1:0] rw;
        logic              regwr;
        logic              load;
    } ent_t;

    ent_t             pipe_q [1:DEPTH];
    ent_t             issue_ent;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             ld_a;
    logic             ld_b;
    logic             stall;

    function automatic logic src_hit(
        input ent_t              e,
        input logic [RIDX_W-1:0] s,
        input logic              u
    );
        return e.valid && e.regwr &&
               (e.rw == s) && (s != '0) && u;
    endfunction

    // Youngest producer per source; remember if it is a late load
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (src_hit(pipe_q[k], hz.issue_rs, hz.use_rs)) begin
                sel_a = SEL_W'(k);
                ld_a  = pipe_q[k].load && (k < LOAD_AVAIL);
            end
            if (src_hit(pipe_q[k], hz.issue_rt, hz.use_rt)) begin
                sel_b = SEL_W'(k);
                ld_b  = pipe_q[k].load && (k < LOAD_AVAIL);
            end
        end
    end

    assign stall = (ld_a | ld_b) & hz.issue_valid &
                   ~hz.flush & Reset_L;

    assign hz.stall_o   = stall;
    assign hz.fwd_sel_a = Reset_L ? sel_a : '0;
    assign hz.fwd_sel_b = Reset_L ? sel_b : '0;

    // Entry entering stage 1: real instruction or bubble
    always_comb begin
        issue_ent       = '0;
        issue_ent.valid = hz.issue_valid & ~stall & ~hz.flush;
        issue_ent.rw    = hz.issue_rw;
        issue_ent.regwr = hz.issue_regwr;
        issue_ent.load  = hz.issue_load;
    end

    // In-flight shift register, advanced every falling edge
    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            for (int k = 1; k <= DEPTH; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[1] <= issue_ent;
            for (int k = 2; k <= DEPTH; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

`ifdef HZT_STALL_CNT_EN
    logic [15:0] cnt_q;

    // Saturating count of cycles spent stalled
    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign hz.stall_cnt = cnt_q;
`else
    assign hz.stall_cnt = 16'd0;
`endif

endmodule

// File: doc/pipe_hazard_tracker.md
PIPE_HAZARD_TRACKER -- requirements
Module: pipe_hazard_tracker

Interface
REQ-001 SHALL provide parameter DEPTH, default 3, number of in-flight stages tracked after issue (stage 1 = EX, 2 = MEM, 3 = WB); legal range 2..8.
REQ-002 SHALL provide parameter RIDX_W, default 5, register index width.
REQ-003 SHALL provide parameter LOAD_AVAIL, default 2, lowest stage whose forwarded value is valid for a load; legal range 1..DEPTH.
REQ-004 SHALL provide parameter SEL_W, default 2, forward-select width; it must be at least clog2(DEPTH+1).
REQ-005 CLK  in  1  single clock; all state updates on the falling edge.
REQ-006 Reset_L  in  1  asynchronous, active-low reset.
REQ-007 issue_valid  in  1  an instruction is present in ID.
REQ-008 issue_rs, issue_rt  in  RIDX_W each  source register indices.
REQ-009 use_rs, use_rt  in  1 each  the matching source is actually read.
REQ-010 issue_rw  in  RIDX_W  destination index.
REQ-011 issue_regwr, issue_load  in  1 each  writes a register / is a load.
REQ-012 flush  in  1  the ID instruction is wrong-path (taken branch or jump).
REQ-013 stall_o  out  1  hold PC and IF/ID; insert a bubble.
REQ-014 fwd_sel_a, fwd_sel_b  out  SEL_W each  0 = register file, k = stage-k result.
REQ-015 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-016 SHALL hold DEPTH entries {valid, rw, regwr, load} as a shift register; every falling edge, entry k+1 <= entry k and the oldest entry is discarded, with no downstream stall.
REQ-017 SHALL load entry 1 from the issue fields when issue_valid=1, stall_o=0 and flush=0; otherwise it SHALL load a bubble (valid=0).
REQ-018 Entry k SHALL match source s when valid=1, regwr=1, rw==s, s!=0, and the use bit for s is 1.
REQ-019 fwd_sel_a/b SHALL be combinational and equal the smallest matching k (youngest producer); 0 if no match.
REQ-020 SHALL compute the hazard term as 1 when either source's youngest match is a load entry with k < LOAD_AVAIL.
REQ-021 stall_o SHALL be combinational: hazard AND issue_valid AND NOT flush.
REQ-022 While stall_o=1, fwd_sel outputs SHALL still reflect the current match; the consumer SHALL ignore them.
REQ-023 rs==rt with a single producer SHALL give fwd_sel_a == fwd_sel_b.
REQ-024 Register index 0 SHALL never match, even when regwr=1.

Reset
REQ-025 Reset_L=0 SHALL immediately clear every entry valid bit, with no clock required.
REQ-026 During reset, stall_o=0, fwd_sel_a=0, fwd_sel_b=0 and stall_cnt=0.
REQ-027 Reset asserted mid-stall SHALL drop stall_o in the same delta and discard all in-flight entries.
REQ-028 After Reset_L rises, the first falling edge SHALL issue normally.

Configuration
REQ-029 Macro HZT_STALL_CNT_EN defined: on each falling edge with stall_o=1, stall_cnt SHALL increment by 1, saturating at 16'hFFFF; when stall_o=0 it SHALL hold.
REQ-030 Macro HZT_STALL_CNT_EN undefined: stall_cnt SHALL be constant 0, with no counter flops.

Verification
REQ-031 Back-to-back ALU ops: issue add r3 (rw=3, regwr), then sub reading rs=3 -> fwd_sel_a=1, stall_o=0; one cycle later another reader of r3 -> fwd_sel_a=2.
REQ-032 Load-use: lw r5 then add rs=5, defaults -> stall_o=1 for exactly one cycle, stall_cnt 0->1 (macro on); the next cycle gives fwd_sel_a=2, stall_o=0.
REQ-033 Youngest wins: r7 written in stages 1 and 2, then a reader with rt=7, use_rt=1 -> fwd_sel_b=1; the same reader with use_rt=0 -> fwd_sel_b=0.
REQ-034 Flush: load r4 in stage 1, with a reader of r4 and flush=1 -> stall_o=0 and entry 1 becomes a bubble (the next reader of rw=4 sees no stage-1 match); r0 writer then r0 reader -> fwd_sel_a=0.
REQ-035 Reset/saturation: assert Reset_L=0 during a stall -> stall_o=0 at once and stall_cnt=0; with the counter preset near 16'hFFFE, three stall cycles -> stall_cnt holds 16'hFFFF.
REQ-036 Parameters: DEPTH=5, LOAD_AVAIL=4, then lw r9 followed immediately by a reader -> stall_o=1 for 3 consecutive cycles, then fwd_sel_a=4.
